led_bcm_driver: RTL and testbench
=================================

LED_BCM_DRIVER -- requirements
Module: led_bcm_driver

Interface
REQ-001 SHALL have parameter COLS, default 64: columns shifted per row; power of two, at least 2.
REQ-002 SHALL have parameter ADDR_BITS, default 5: row-address width; scan rows = 2**ADDR_BITS.
REQ-003 SHALL have parameter BITS, default 8: colour depth per channel, equal to the bit-plane count.
REQ-004 SHALL have parameter BASE, default 16: display cycles for plane 0.
REQ-005 SHALL have ports: clk input 1, the clock.
REQ-006 SHALL have ports: reset input 1, synchronous, active-high.
REQ-007 SHALL have ports: pix_valid input 1, upstream pixel pair valid.
REQ-008 SHALL have ports: pix_ready output 1, the driver accepts a pixel pair.
REQ-009 SHALL have ports: pix0, pix1 inputs 3*BITS each, {b,g,r} with r in the low BITS, for the upper and lower half-panel.
REQ-010 SHALL have ports: cur_col output clog2(COLS), cur_row output ADDR_BITS and cur_plane output clog2(BITS), identifying the pixel pair expected next.
REQ-011 SHALL have ports: frame_start output 1, a one-cycle pulse.
REQ-012 SHALL have panel outputs: rgb0 3, rgb1 3, addr ADDR_BITS, blank 1, latch 1, sclk 1; all registered.

Function
REQ-013 SHALL use the states S_SHIFT_LO, S_SHIFT_HI, S_HOLD and S_LATCH.
REQ-014 S_SHIFT_LO: pix_ready SHALL be 1 (combinational on state) and sclk SHALL be 0.
- On transfer (pix_valid & pix_ready): rgb0 <= bit cur_plane of each pix0 channel; rgb1 likewise from pix1.
- Then go to S_SHIFT_HI.
- With no transfer: hold state, hold all outputs, keep sclk low.
REQ-015 S_SHIFT_HI SHALL drive sclk 1 for exactly one cycle.
- cur_col SHALL increment.
- If cur_col was COLS-1: cur_col wraps to 0, go to S_HOLD; otherwise go to S_SHIFT_LO.
REQ-016 pix_ready SHALL be 0 in every state except S_SHIFT_LO.
REQ-017 The display timer SHALL have width BITS+clog2(BASE).
- It decrements each cycle while nonzero, in every state.
REQ-018 S_HOLD SHALL go to S_LATCH in the first cycle in which the timer is 0.
REQ-019 S_LATCH SHALL last exactly one cycle.
- blank=1 and latch=1.
- addr <= cur_row.
- Timer <= BASE << cur_plane.
- Next state: S_SHIFT_LO.
REQ-020 In S_LATCH the plane/row pointers SHALL advance.
- cur_plane SHALL increment.
- At BITS-1, cur_plane wraps to 0 and cur_row increments, wrapping from 2**ADDR_BITS-1 to 0.
REQ-021 blank SHALL be 0 in the cycle after S_LATCH.
- blank SHALL stay 0 until the next S_LATCH.
- Exception: before the first S_LATCH after reset, blank SHALL stay 1.
REQ-022 The next plane SHALL be shifted while the current plane is displayed.
- If shifting outlasts BASE << plane, latch occurs immediately on the S_HOLD entry; that plane displays longer, which is accepted.
REQ-023 frame_start SHALL be 1 for the single cycle of the transfer with cur_col=0, cur_row=0, cur_plane=0.
REQ-024 Pixel order on pix0/pix1 SHALL be column-major within each (row, plane) line; planes 0..BITS-1 per row; rows ascending.
- Upstream re-sends each row BITS times.

Reset
REQ-025 On reset the driver SHALL set: state S_SHIFT_LO, timer 0, cur_col/cur_row/cur_plane 0.
- Outputs: rgb0=rgb1=0, addr=0, blank=1, latch=0, sclk=0, frame_start=0.
REQ-026 Reset asserted mid-operation SHALL abandon the current line.
- Reset values SHALL appear the cycle after reset is sampled.
- No latch pulse SHALL be emitted.

Verification (COLS=4, ADDR_BITS=1, BITS=2, BASE=16)
REQ-027 Reset, pix_valid=0 for 10 cycles -> blank=1, sclk=0, latch=0 and pix_ready=1 throughout; no state change.
REQ-028 pix_valid held 1 -> exactly 4 sclk pulses (one high cycle every 2 cycles), then 1-cycle latch with blank=1 and addr=0.
- The plane-1 latch occurs 16 cycles after that first unblank.
- The next latch (row 1, plane 0) occurs 32 cycles later.
REQ-029 pix_valid dropped 5 cycles while cur_col=2 -> sclk low, pix_ready high and cur_col=2 for those 5 cycles; the shift resumes on re-assertion.
REQ-030 pix0 r=2'b10, g=2'b01, b=2'b00 for every pixel -> plane 0 shifts rgb0=3'b010 and plane 1 shifts rgb0=3'b001.
REQ-031 Run past the row 1 / plane 1 latch -> cur_row=0 and cur_plane=0; frame_start pulses once on the next col-0 transfer; addr=1 is held during the final plane.
REQ-032 Reset asserted during S_SHIFT_HI at cur_col=3 -> next cycle: blank=1, sclk=0, cur_col=0, and no latch pulse.

Source files
------------

// File: rtl/led_bcm_driver.sv
// led_bcm_driver: drives a two-half HUB75-style LED panel using binary code
// modulation. One (row, plane) line of COLS pixel pairs is shifted out while
// the previously latched line is lit for BASE << plane cycles.
module led_bcm_driver #(
  parameter int COLS      = 64,
  parameter int ADDR_BITS = 5,
  parameter int BITS      = 8,
  parameter int BASE      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [3*BITS-1:0]       pix0,
  input  logic [3*BITS-1:0]       pix1,
  output logic [$clog2(COLS)-1:0] cur_col,
  output logic [ADDR_BITS-1:0]    cur_row,
  output logic [$clog2(BITS)-1:0] cur_plane,
  output logic                    frame_start,
  output logic [2:0]              rgb0,
  output logic [2:0]              rgb1,
  output logic [ADDR_BITS-1:0]    addr,
  output logic                    blank,
  output logic                    latch,
  output logic                    sclk
);

  localparam int COL_W   = $clog2(COLS);
  localparam int PLANE_W = $clog2(BITS);
  localparam int TIMER_W = BITS + $clog2(BASE);

  localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(COLS - 1);
  localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(BITS - 1);
  localparam logic [TIMER_W-1:0] BASE_T     = TIMER_W'(BASE);

  typedef enum logic [1:0] {
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_HOLD,
    S_LATCH
  } state_t;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [COL_W-1:0]     cur_col_q, cur_col_d;
  logic [ADDR_BITS-1:0] cur_row_q, cur_row_d;
  logic [PLANE_W-1:0]   cur_plane_q, cur_plane_d;
  logic [2:0]           rgb0_q, rgb0_d;
  logic [2:0]           rgb1_q, rgb1_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 blank_q, blank_d;
  logic                 latch_q, latch_d;
  logic                 sclk_q, sclk_d;

  // Bit cur_plane of each colour channel, packed {b,g,r}.
  logic [2:0] plane_bits0;
  logic [2:0] plane_bits1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic [BITS-1:0] chan0;
    logic [BITS-1:0] chan1;
    assign chan0           = pix0[gi*BITS +: BITS];
    assign chan1           = pix1[gi*BITS +: BITS];
    assign plane_bits0[gi] = chan0[cur_plane_q];
    assign plane_bits1[gi] = chan1[cur_plane_q];
  end

  assign pix_ready   = (state_q == S_SHIFT_LO);
  assign frame_start = pix_valid && pix_ready && (cur_col_q == '0) &&
                       (cur_row_q == '0) && (cur_plane_q == '0);

  // Next-state logic; panel outputs are computed one cycle ahead so that they
  // come straight from flops and line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    timer_d     = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
    cur_col_d   = cur_col_q;
    cur_row_d   = cur_row_q;
    cur_plane_d = cur_plane_q;
    rgb0_d      = rgb0_q;
    rgb1_d      = rgb1_q;
    addr_d      = addr_q;
    blank_d     = blank_q;
    latch_d     = 1'b0;
    sclk_d      = 1'b0;

    case (state_q)
      S_SHIFT_LO: begin
        if (pix_valid) begin
          rgb0_d  = plane_bits0;
          rgb1_d  = plane_bits1;
          sclk_d  = 1'b1;
          state_d = S_SHIFT_HI;
        end
      end

      S_SHIFT_HI: begin
        if (cur_col_q == LAST_COL) begin
          cur_col_d = '0;
          state_d   = S_HOLD;
        end else begin
          cur_col_d = cur_col_q + 1'b1;
          state_d   = S_SHIFT_LO;
        end
      end

      S_HOLD: begin
        // The lit line has had its full time; blank, strobe the new line in
        // and start its display time from the latch cycle.
        if (timer_q == '0) begin
          state_d = S_LATCH;
          blank_d = 1'b1;
          latch_d = 1'b1;
          addr_d  = cur_row_q;
          timer_d = BASE_T << cur_plane_q;
        end
      end

      S_LATCH: begin
        blank_d = 1'b0;
        state_d = S_SHIFT_LO;
        if (cur_plane_q == LAST_PLANE) begin
          cur_plane_d = '0;
          cur_row_d   = cur_row_q + 1'b1;
        end else begin
          cur_plane_d = cur_plane_q + 1'b1;
        end
      end

      default: state_d = S_SHIFT_LO;
    endcase
  end

  // State and registered outputs; reset abandons any line in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_SHIFT_LO;
      timer_q     <= '0;
      cur_col_q   <= '0;
      cur_row_q   <= '0;
      cur_plane_q <= '0;
      rgb0_q      <= '0;
      rgb1_q      <= '0;
      addr_q      <= '0;
      blank_q     <= 1'b1;
      latch_q     <= 1'b0;
      sclk_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cur_col_q   <= cur_col_d;
      cur_row_q   <= cur_row_d;
      cur_plane_q <= cur_plane_d;
      rgb0_q      <= rgb0_d;
      rgb1_q      <= rgb1_d;
      addr_q      <= addr_d;
      blank_q     <= blank_d;
      latch_q     <= latch_d;
      sclk_q      <= sclk_d;
    end
  end

  assign cur_col   = cur_col_q;
  assign cur_row   = cur_row_q;
  assign cur_plane = cur_plane_q;
  assign rgb0      = rgb0_q;
  assign rgb1      = rgb1_q;
  assign addr      = addr_q;
  assign blank     = blank_q;
  assign latch     = latch_q;
  assign sclk      = sclk_q;

endmodule

// File: tb/tb_led_bcm_driver.sv
// Testbench for led_bcm_driver with a 4-column, 2-row, 2-plane panel.
module tb_led_bcm_driver;

  localparam int COLS      = 4;
  localparam int ADDR_BITS = 1;
  localparam int BITS      = 2;
  localparam int BASE      = 16;
  localparam int ROWS      = 1 << ADDR_BITS;
  localparam int PW        = 3 * BITS;
  localparam int FRAME     = COLS * BITS * ROWS;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 pix_valid = 1'b0;
  logic                 pix_ready;
  logic [PW-1:0]        pix0 = '0;
  logic [PW-1:0]        pix1 = '0;
  logic [1:0]           cur_col;
  logic [ADDR_BITS-1:0] cur_row;
  logic [0:0]           cur_plane;
  logic                 frame_start;
  logic [2:0]           rgb0;
  logic [2:0]           rgb1;
  logic [ADDR_BITS-1:0] addr;
  logic                 blank;
  logic                 latch;
  logic                 sclk;

  int checks = 0;
  int errors = 0;

  led_bcm_driver #(
    .COLS(COLS), .ADDR_BITS(ADDR_BITS), .BITS(BITS), .BASE(BASE)
  ) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix0(pix0), .pix1(pix1), .cur_col(cur_col), .cur_row(cur_row),
    .cur_plane(cur_plane), .frame_start(frame_start), .rgb0(rgb0), .rgb1(rgb1),
    .addr(addr), .blank(blank), .latch(latch), .sclk(sclk)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    pix_valid = 1'b0;
    pix0      = '0;
    pix1      = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Panel bits for plane p of a {b,g,r} pixel.
  function automatic logic [2:0] bcm_bits(input logic [PW-1:0] pix, input int p);
    logic [PW-1:0] s;
    s = pix >> p;
    return {s[2*BITS], s[BITS], s[0]};
  endfunction

  typedef struct {
    logic [PW-1:0] pix0;
    logic [PW-1:0] pix1;
    logic [1:0]    col;
    logic [0:0]    plane;
    logic [2:0]    rgb0;
    logic [2:0]    rgb1;
  } vec_t;

  vec_t vec [8];

  // Reference-model state for the random run.
  int         k, latch_due, prev_l, prev_d, line_row, line_plane, col_m, row_m, plane_m;
  bit         pend, line_wait, have_latched, exp_ready, exp_latch, xfer;
  logic [2:0] pend_rgb0, pend_rgb1;
  logic [ADDR_BITS-1:0] exp_addr;

  int lat_cyc[$];
  int lat_addr[$];
  int fs_cyc[$];

  initial begin
    int exp_lc [5];
    int exp_la [5];
    int n;

    // {pix0, pix1, col, plane, rgb0, rgb1}; pixel = {b1 b0 g1 g0 r1 r0}
    vec[0] = '{6'b000110, 6'b111111, 2'd0, 1'b0, 3'b010, 3'b111};
    vec[1] = '{6'b000000, 6'b010101, 2'd1, 1'b0, 3'b000, 3'b111};
    vec[2] = '{6'b101010, 6'b000001, 2'd2, 1'b0, 3'b000, 3'b001};
    vec[3] = '{6'b010000, 6'b000100, 2'd3, 1'b0, 3'b100, 3'b010};
    vec[4] = '{6'b000110, 6'b101010, 2'd0, 1'b1, 3'b001, 3'b111};
    vec[5] = '{6'b010101, 6'b100000, 2'd1, 1'b1, 3'b000, 3'b100};
    vec[6] = '{6'b001000, 6'b000010, 2'd2, 1'b1, 3'b010, 3'b001};
    vec[7] = '{6'b111111, 6'b000000, 2'd3, 1'b1, 3'b111, 3'b000};

    exp_lc = '{9, 26, 59, 76, 109};
    exp_la = '{0, 0, 1, 1, 0};

    // Idle after reset: blanked, no clocks, ready, nothing moves.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_blank", blank, 1);
      chk("idle_sclk", sclk, 0);
      chk("idle_latch", latch, 0);
      chk("idle_ready", pix_ready, 1);
      chk("idle_col", cur_col, 0);
      chk("idle_rgb0", rgb0, 0);
      chk("idle_addr", addr, 0);
      chk("idle_frame_start", frame_start, 0);
    end
    $display("idle: 10 cycles observed");

    // Table vectors: one pixel pair per record, through two planes of row 0.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (!pix_ready && n < 100) begin @(posedge clk); #1; n++; end
      chk("vec_ready_wait", (n < 100), 1);
      pix0 = vec[i].pix0;
      pix1 = vec[i].pix1;
      pix_valid = 1'b1;
      @(negedge clk);
      chk("vec_col", cur_col, vec[i].col);
      chk("vec_plane", cur_plane, vec[i].plane);
      @(posedge clk); #1;
      pix_valid = 1'b0;
      @(negedge clk);
      chk("vec_sclk", sclk, 1);
      chk("vec_rgb0", rgb0, vec[i].rgb0);
      chk("vec_rgb1", rgb1, vec[i].rgb1);
      $display("vec %0d: pix0=%b pix1=%b rgb0=%b rgb1=%b", i, vec[i].pix0, vec[i].pix1, rgb0, rgb1);
      @(posedge clk); #1;
    end

    // pix_valid held high from reset: latch schedule across a full frame.
    do_reset();
    pix_valid = 1'b1;
    pix0 = 6'b000110;
    pix1 = 6'b000000;
    for (int c = 0; c <= 110; c++) begin
      @(negedge clk);
      if (c < 9) chk("hold_sclk_pattern", sclk, (c % 2 == 1 && c < 8));
      if (c == 1) chk("hold_rgb0_plane0", rgb0, 3'b010);
      if (c == 11) chk("hold_rgb0_plane1", rgb0, 3'b001);
      if (c == 8) chk("hold_blank_before_first", blank, 1);
      if (c == 9) chk("hold_blank_at_latch", blank, 1);
      if (c == 10) chk("hold_unblank", blank, 0);
      if (c == 77) begin
        chk("wrap_row", cur_row, 0);
        chk("wrap_plane", cur_plane, 0);
      end
      if (c == 77 || c == 90 || c == 108) chk("final_plane_addr", addr, 1);
      if (latch) begin lat_cyc.push_back(c); lat_addr.push_back(int'(addr)); end
      if (frame_start) fs_cyc.push_back(c);
    end
    chk("hold_latch_count", lat_cyc.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < lat_cyc.size()) begin
        chk("hold_latch_cycle", lat_cyc[i], exp_lc[i]);
        chk("hold_latch_addr", lat_addr[i], exp_la[i]);
        $display("latch %0d: cycle=%0d addr=%0d", i, lat_cyc[i], lat_addr[i]);
      end
    end
    chk("frame_start_count", fs_cyc.size(), 2);
    if (fs_cyc.size() == 2) begin
      chk("frame_start_first", fs_cyc[0], 0);
      chk("frame_start_second", fs_cyc[1], 77);
    end

    // Stall at cur_col=2 for five cycles, then resume.
    do_reset();
    pix_valid = 1'b1;
    n = 0;
    while (!(pix_ready && cur_col == 2'd2) && n < 50) begin @(posedge clk); #1; n++; end
    chk("stall_reach_col2", (n < 50), 1);
    pix_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_sclk", sclk, 0);
      chk("stall_ready", pix_ready, 1);
      chk("stall_col", cur_col, 2);
      @(posedge clk); #1;
    end
    pix_valid = 1'b1;
    @(posedge clk); #1;
    chk("stall_resume_sclk", sclk, 1);
    @(posedge clk); #1;
    chk("stall_resume_col", cur_col, 3);
    chk("stall_resume_ready", pix_ready, 1);
    $display("stall: 5 idle cycles at col 2, resumed");

    // Reset during the col-3 sclk pulse of a line, after the panel is lit.
    do_reset();
    pix_valid = 1'b1;
    n = 0;
    while (!(sclk && cur_col == 2'd3 && !blank) && n < 100) begin @(posedge clk); #1; n++; end
    chk("rst_reach_hi_col3", (n < 100), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_blank", blank, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_col", cur_col, 0);
    chk("rst_latch", latch, 0);
    chk("rst_ready", pix_ready, 1);
    reset = 1'b0;
    pix_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_no_latch", latch, 0);
    end
    $display("mid-line reset: outputs back to reset values");

    // Random run against the line-level reference model.
    do_reset();
    k = 0; pend = 0; line_wait = 0; have_latched = 0;
    prev_l = -1; prev_d = 0; latch_due = -1; exp_addr = '0;
    line_row = 0; line_plane = 0; pend_rgb0 = '0; pend_rgb1 = '0;
    for (int c = 0; c < 3000; c++) begin
      pix_valid = ($urandom_range(0, 3) != 0);
      pix0 = PW'($urandom);
      pix1 = PW'($urandom);
      @(negedge clk);
      exp_ready = !pend && !line_wait;
      exp_latch = (latch_due == c);
      chk("rnd_sclk", sclk, pend);
      if (pend) begin
        chk("rnd_rgb0", rgb0, pend_rgb0);
        chk("rnd_rgb1", rgb1, pend_rgb1);
      end
      chk("rnd_ready", pix_ready, exp_ready);
      chk("rnd_latch", latch, exp_latch);
      chk("rnd_blank", blank, (exp_latch || !have_latched));
      chk("rnd_addr", addr, exp_latch ? line_row : int'(exp_addr));
      xfer = pix_valid && exp_ready;
      chk("rnd_frame_start", frame_start, (xfer && (k % FRAME == 0)));
      pend = 0;
      if (exp_latch) begin
        prev_l       = c;
        prev_d       = BASE << line_plane;
        exp_addr     = ADDR_BITS'(line_row);
        have_latched = 1;
        line_wait    = 0;
        $display("rnd latch: cycle=%0d row=%0d plane=%0d", c, line_row, line_plane);
      end
      if (xfer) begin
        col_m   = k % COLS;
        plane_m = (k / COLS) % BITS;
        row_m   = (k / (COLS * BITS)) % ROWS;
        chk("rnd_col", cur_col, col_m);
        chk("rnd_plane", cur_plane, plane_m);
        chk("rnd_row", cur_row, row_m);
        pend      = 1;
        pend_rgb0 = bcm_bits(pix0, plane_m);
        pend_rgb1 = bcm_bits(pix1, plane_m);
        k++;
        if (col_m == COLS - 1) begin
          line_wait  = 1;
          line_row   = row_m;
          line_plane = plane_m;
          if (prev_l < 0 || c + 3 > prev_l + prev_d + 1) latch_due = c + 3;
          else latch_due = prev_l + prev_d + 1;
        end
      end
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
